// File: rtl/serial_frame_tx.sv
// serial_frame_tx: start/data/stop serial framer, LSB first, each bit held CLKS_PER_BIT clocks.
// All outputs come straight from flops; the line idles high.
module serial_frame_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             R,
    input  logic [WIDTH-1:0] Din,
    input  logic             load,
    output logic             D,
    output logic             Db,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t           r_state;
    logic [7:0]       r_cnt;
    logic [4:0]       r_bit;
    logic [WIDTH-1:0] r_sh;
    logic             r_d;
    logic             r_db;
    logic             r_busy;
    logic             r_done;
    logic             w_last;
    logic             w_last_bit;
    logic [WIDTH-1:0] w_shr;
    assign w_last     = r_cnt == 8'(CLKS_PER_BIT - 1);
    assign w_last_bit = r_bit == 5'(WIDTH - 1);
    assign w_shr      = r_sh >> 1;
    assign D    = r_d;
    assign Db   = r_db;
    assign busy = r_busy;
    assign done = r_done;
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_sh    <= '0;
            r_d     <= 1'b1;
            r_db    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state != IDLE)
                r_cnt <= w_last ? '0 : r_cnt + 8'd1;
            case (r_state)
                IDLE: if (load) begin
                    r_state <= START;
                    r_sh    <= Din;
                    r_d     <= 1'b0;
                    r_db    <= 1'b1;
                    r_busy  <= 1'b1;
                end
                START: if (w_last) begin
                    r_state <= DATA;
                    r_bit   <= '0;
                    r_d     <= r_sh[0];
                    r_db    <= ~r_sh[0];
                end
                DATA: if (w_last) begin
                    if (w_last_bit) begin
                        r_state <= STOP;
                        r_d     <= 1'b1;
                        r_db    <= 1'b0;
                    end else begin
                        r_bit <= r_bit + 5'd1;
                        r_sh  <= w_shr;
                        r_d   <= w_shr[0];
                        r_db  <= ~w_shr[0];
                    end
                end
                STOP: if (w_last) begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: drives a default (8x4) and a minimal (1x1) framer against a frame-level model.
module tb_serial_frame_tx;
    logic       clk = 1'b0;
    logic       R = 1'b0;
    logic [7:0] din_a = '0;
    logic       load_a = 1'b0;
    logic       din_b = 1'b0;
    logic       load_b = 1'b0;
    logic       d_a, db_a, busy_a, done_a;
    logic       d_b, db_b, busy_b, done_b;
    int         n_cmp = 0;
    int         n_fail = 0;
    int         mw[2] = '{8, 1};
    int         mc[2] = '{4, 1};
    int         m_idx[2] = '{40, 3};
    logic       m_done[2] = '{1'b0, 1'b0};
    logic [15:0] m_data[2] = '{16'h0, 16'h0};

    always #5 clk = ~clk;

    serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(4)) dut_a (
        .clk(clk), .R(R), .Din(din_a), .load(load_a),
        .D(d_a), .Db(db_a), .busy(busy_a), .done(done_a));
    serial_frame_tx #(.WIDTH(1), .CLKS_PER_BIT(1)) dut_b (
        .clk(clk), .R(R), .Din(din_b), .load(load_b),
        .D(d_b), .Db(db_b), .busy(busy_b), .done(done_b));

    // Frame length is (WIDTH+2)*CLKS_PER_BIT; m_idx == that length means idle.
    function automatic int frame_len(input int k);
        return (mw[k] + 2) * mc[k];
    endfunction

    function automatic logic line_level(input int k);
        int b;
        if (m_idx[k] >= frame_len(k)) return 1'b1;
        b = m_idx[k] / mc[k];
        if (b == 0) return 1'b0;
        if (b <= mw[k]) return m_data[k][b-1];
        return 1'b1;
    endfunction

    task automatic model_edge(input int k, input logic ld, input logic [15:0] d);
        int t;
        t = frame_len(k);
        m_done[k] = 1'b0;
        if (m_idx[k] < t - 1) m_idx[k]++;
        else if (m_idx[k] == t - 1) begin
            m_idx[k] = t;
            m_done[k] = 1'b1;
        end else if (ld) begin
            m_data[k] = d;
            m_idx[k] = 0;
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_idx[k] = frame_len(k);
            m_done[k] = 1'b0;
        end
    endtask

    task automatic cmp(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        logic e;
        e = line_level(0);
        cmp("A.D", d_a, e);
        cmp("A.Db", db_a, ~e);
        cmp("A.busy", busy_a, m_idx[0] < frame_len(0));
        cmp("A.done", done_a, m_done[0]);
        e = line_level(1);
        cmp("B.D", d_b, e);
        cmp("B.Db", db_b, ~e);
        cmp("B.busy", busy_b, m_idx[1] < frame_len(1));
        cmp("B.done", done_b, m_done[1]);
    endtask

    // One clock: drive at the falling edge, model the rising edge, check at the next falling edge.
    task automatic step(input logic la, input logic [7:0] da, input logic lb, input logic dbv);
        load_a = la;
        din_a  = da;
        load_b = lb;
        din_b  = dbv;
        @(posedge clk);
        if (R) begin
            model_edge(0, la, {8'h0, da});
            model_edge(1, lb, {15'h0, dbv});
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, din_a, 1'b0, din_b);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        check_all();
        idle_steps(2);
        R = 1'b1;
        idle_steps(2);
        // A5 single pulse; B sends 0
        step(1'b1, 8'hA5, 1'b1, 1'b0);
        idle_steps(45);
        // FF captured, Din changed to 00 at cycle 5
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        for (int i = 2; i <= 45; i++) step(1'b0, (i >= 5) ? 8'h00 : 8'hFF, 1'b0, 1'b0);
        // load held with 3C: back-to-back frames
        for (int i = 0; i < 84; i++) step(1'b1, 8'h3C, 1'b1, 1'b1);
        idle_steps(45);
        // reloads at cycles 10 and 20 are ignored
        step(1'b1, 8'h96, 1'b0, 1'b0);
        for (int i = 2; i <= 45; i++) step(i == 10 || i == 20, 8'h0F, 1'b0, 1'b0);
        // async reset mid-frame at cycle 17
        step(1'b1, 8'hC3, 1'b1, 1'b1);
        idle_steps(16);
        #2 R = 1'b0;
        #1;
        model_reset();
        cmp("rst.D", d_a, 1'b1);
        cmp("rst.Db", db_a, 1'b0);
        cmp("rst.busy", busy_a, 1'b0);
        cmp("rst.done", done_a, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) step(1'b1, 8'hEE, 1'b1, 1'b1);
        R = 1'b1;
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        idle_steps(45);
        // randomized traffic
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 7) == 0, 8'($urandom), $urandom_range(0, 2) == 0, 1'($urandom));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_frame_tx.md
SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of data bits per frame (legal 1..16).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 4, clock cycles each serial bit is held (legal 1..255).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port R  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port Din  input  WIDTH  parallel data to transmit.
REQ-006 SHALL have port load  input  1  request to start a frame with Din.
REQ-007 SHALL have port D  output  1  serial line, registered, idle high.
REQ-008 SHALL have port Db  output  1  always the complement of D.
REQ-009 SHALL have port busy  output  1  high while a frame is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse marking end of frame.

Function
REQ-011 SHALL implement a four-state FSM: IDLE, START, DATA, STOP.
REQ-012 In IDLE, D=1, busy=0; load=1 at a rising edge SHALL capture Din into a WIDTH-bit shift register and enter START.
REQ-013 START SHALL drive D=0 for exactly CLKS_PER_BIT cycles, then enter DATA.
REQ-014 DATA SHALL drive captured bits LSB first, each for exactly CLKS_PER_BIT cycles, tracked by a bit counter 0..WIDTH-1.
REQ-015 After bit WIDTH-1 completes, DATA SHALL enter STOP; STOP SHALL drive D=1 for exactly CLKS_PER_BIT cycles, then return to IDLE.
REQ-016 The bit-period counter SHALL count 0..CLKS_PER_BIT-1 and wrap to 0 on each bit boundary; no extra cycles between bits.
REQ-017 busy SHALL be 1 from the edge that accepts load through the last STOP cycle: exactly (WIDTH+2)*CLKS_PER_BIT cycles.
REQ-018 done SHALL be 1 for exactly one cycle: the first IDLE cycle after STOP; 0 at all other times.
REQ-019 load while busy=1 SHALL be ignored; no queuing.
REQ-020 Changes on Din after capture SHALL NOT affect the frame in progress.
REQ-021 load=1 during the done cycle SHALL be accepted at that edge, giving back-to-back frames with exactly one idle (D=1) cycle between the stop bit and the next start bit.
REQ-022 load held high continuously SHALL transmit repeated frames of the then-current Din, each separated per REQ-021.
REQ-023 D, Db, busy, done SHALL be driven directly from flip-flops (no combinational path from Din/load).

Reset
REQ-024 R=0 SHALL immediately, without a clock edge, force state IDLE, D=1, Db=0, busy=0, done=0, and clear all counters and the shift register.
REQ-025 R=0 mid-frame SHALL abort the frame with no done pulse; after R returns to 1, the first load SHALL start a complete new frame.
REQ-026 While R=0, load SHALL be ignored; R release SHALL take effect only on the first rising clk edge at which R=1.

Verification
REQ-027 Defaults, Din=8'hA5, load pulse one cycle -> D = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; busy high 40 cycles; done high in cycle 41 only.
REQ-028 Din=8'hFF then load, Din changed to 8'h00 at cycle 5 -> data bits all 1; Db always equals ~D.
REQ-029 load held high with Din=8'h3C for 2 frames -> two identical frames, single D=1 cycle between first stop bit and second start bit; done pulses twice.
REQ-030 load re-asserted at cycles 10 and 20 of a frame -> ignored; frame length still 40 cycles; exactly one done pulse.
REQ-031 R=0 at cycle 17 of a frame (between clock edges) -> D=1, busy=0 immediately; no done pulse; subsequent load of 8'h5A yields a full correct frame.
REQ-032 WIDTH=1, CLKS_PER_BIT=1, Din=1'b0 -> D = 0,0,1 over 3 cycles; busy 3 cycles; done in cycle 4.
